// File: rtl/hyperspace_frame_ctrl.sv
// hyperspace_frame_ctrl: frames the GPIO sample stream into the spectrometer datapath and counts spectrum beats back out.
module hyperspace_frame_ctrl #(
  parameter int IN_FRAME  = 2048,
  parameter int OUT_FRAME = 1536,
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       num_frames,
  input  logic             s_in_valid,
  output logic             s_in_ready,
  input  logic [IN_W-1:0]  s_in_data,
  input  logic             s_in_last,
  output logic             m_dp_valid,
  input  logic             m_dp_ready,
  output logic [IN_W-1:0]  m_dp_data,
  output logic             m_dp_last,
  input  logic             s_dp_valid,
  output logic             s_dp_ready,
  input  logic [OUT_W-1:0] s_dp_data,
  input  logic             s_dp_last,
  output logic             m_out_valid,
  input  logic             m_out_ready,
  output logic [OUT_W-1:0] m_out_data,
  output logic             m_out_last,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frame_cnt,
  output logic             err_in_last,
  output logic             err_out_last
);
  localparam int ICW = $clog2(IN_FRAME);
  localparam int OCW = $clog2(OUT_FRAME);
  localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_FRAME - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_FRAME - 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] nf_q, nf_d, frame_cnt_q, frame_cnt_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic err_in_q, err_in_d, err_out_q, err_out_d, out_done_q, out_done_d, done_q, done_d;
  logic in_en, out_en, in_at_last, out_at_last, in_acc, out_acc, frame_end;
  // abort closes every handshake in its own cycle so no beat is half-counted
  assign in_en       = (state_q == FEED) && !abort;
  assign out_en      = (state_q != IDLE) && !out_done_q && !abort;
  assign in_at_last  = in_cnt_q == IN_LAST;
  assign out_at_last = out_cnt_q == OUT_LAST;
  assign m_dp_valid  = in_en && s_in_valid;
  assign s_in_ready  = in_en && m_dp_ready;
  assign m_dp_data   = s_in_data;
  assign m_dp_last   = in_en && in_at_last;
  assign m_out_valid = out_en && s_dp_valid;
  assign s_dp_ready  = out_en && m_out_ready;
  assign m_out_data  = s_dp_data;
  assign m_out_last  = out_en && out_at_last;
  assign in_acc      = m_dp_valid && m_dp_ready;
  assign out_acc     = m_out_valid && m_out_ready;
  assign frame_end   = (in_acc && in_at_last && (out_done_q || (out_acc && out_at_last))) ||
                       ((state_q == DRAIN) && out_acc && out_at_last);
  assign busy         = state_q != IDLE;
  assign done         = done_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_in_last  = err_in_q;
  assign err_out_last = err_out_q;
  always_comb begin
    state_d     = state_q;
    nf_d        = nf_q;
    frame_cnt_d = frame_cnt_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    err_in_d    = err_in_q;
    err_out_d   = err_out_q;
    out_done_d  = out_done_q;
    done_d      = 1'b0;
    if (in_acc) begin
      in_cnt_d = in_at_last ? '0 : in_cnt_q + ICW'(1);
      err_in_d = err_in_q || (s_in_last != in_at_last);
      state_d  = in_at_last ? DRAIN : state_q;
    end
    if (out_acc) begin
      out_cnt_d  = out_at_last ? '0 : out_cnt_q + OCW'(1);
      err_out_d  = err_out_q || (s_dp_last != out_at_last);
      out_done_d = out_done_q || out_at_last;
    end
    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      out_done_d  = 1'b0;
      done_d      = (nf_q != 8'd0) && (frame_cnt_d == nf_q);
      state_d     = done_d ? IDLE : FEED;
    end
    if (state_q == IDLE && start && !abort) begin
      state_d     = FEED;
      nf_d        = num_frames;
      frame_cnt_d = 8'd0;
      err_in_d    = 1'b0;
      err_out_d   = 1'b0;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      out_done_d  = 1'b0;
    end
    if (abort) begin
      state_d    = IDLE;
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      out_done_d = 1'b0;
      done_d     = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      nf_q        <= 8'd0;
      frame_cnt_q <= 8'd0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      err_in_q    <= 1'b0;
      err_out_q   <= 1'b0;
      out_done_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nf_q        <= nf_d;
      frame_cnt_q <= frame_cnt_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      err_in_q    <= err_in_d;
      err_out_q   <= err_out_d;
      out_done_q  <= out_done_d;
      done_q      <= done_d;
    end
  end
endmodule
